fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch and program-counter stage directly upstream of the CPU control FSM.
- On the controller's do_fetch pulse it reads one instruction word from instruction memory over a req/ack handshake, latches it, and presents opcode/isaluop to the controller.
- On do_next it advances the PC (sequential, jump, or taken branch).
- busy is asserted while a fetch is outstanding; the core-level wrapper stalls the controller while busy is high.

Parameters:
- ADDR_WIDTH, 16, PC and instruction-memory address width.
- WORD_SIZE, 16, instruction word width.
- NIB_SIZE, 4, opcode width; opcode = instr[WORD_SIZE-1 -: NIB_SIZE].
- RESET_PC, 0, PC value after reset.
- OP_JMP_CODE, 4'hE, jump opcode.
- OP_BR_CODE, 4'hF, conditional branch opcode.
- TIMEOUT_CYCLES, 255, ack watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- do_fetch  in  1  controller fetch strobe.
- do_next  in  1  controller next-PC strobe.
- take_branch  in  1  branch condition, sampled with do_next.
- jump_target  in  ADDR_WIDTH  absolute jump address, sampled with do_next.
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_WIDTH  memory read address.
- imem_rdata  in  WORD_SIZE  memory read data, valid with imem_ack.
- imem_ack  in  1  read-complete strobe.
- instr  out  WORD_SIZE  latched instruction.
- opcode  out  NIB_SIZE  instr top nibble.
- isaluop  out  1  high when opcode[NIB_SIZE-1]==0 (opcodes 0..7 are ALU ops).
- pc  out  ADDR_WIDTH  current PC.
- busy  out  1  fetch outstanding.
- seq_error  out  1  sticky protocol-violation flag.
- fetch_fault  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: pc=RESET_PC, instr=0, imem_req=0, busy=0, seq_error=0, fetch_fault=0.
  - State returns to IDLE immediately, including mid-fetch; a late ack after reset release is ignored.
- FSM states: IDLE, WAIT.
- IDLE, do_fetch=1, do_next=0:
  - Next cycle: state=WAIT, imem_req=1, imem_addr=pc (registered), busy=1.
- WAIT:
  - imem_req and imem_addr are held stable until ack.
  - On the imem_ack cycle: instr<=imem_rdata, state<=IDLE; the following cycle imem_req=0 and busy=0.
  - Minimum latency: do_fetch to instr valid is 2 cycles (ack on the first WAIT cycle).
  - An ack in IDLE is ignored.
- opcode and isaluop are combinational from the instr register and change only when instr loads.
- IDLE, do_next=1, do_fetch=0 (PC update on the next edge):
  - opcode==OP_JMP_CODE: pc<=jump_target.
  - opcode==OP_BR_CODE and take_branch=1: pc<=pc+1+sext(instr[7:0]).
  - Otherwise (including branch not taken): pc<=pc+1.
  - All PC arithmetic is modulo 2^ADDR_WIDTH (0xFFFF+1 wraps to 0x0000; a negative offset below 0 wraps high).
- Violations: do_fetch or do_next in WAIT, or both high in IDLE:
  - No action is taken.
  - seq_error<=1, sticky until reset.
  - An in-flight fetch continues unaffected.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: the fetch is aborted, instr<=0, state<=IDLE, imem_req drops, fetch_fault<=1 (sticky).
  - If ack and timeout occur in the same cycle, ack wins.
- FETCH_TIMEOUT_EN undefined: no counter, WAIT persists indefinitely, fetch_fault is tied to 0.

Test Plan:
- Reset then do_fetch, mem returns 16'h1234 after 3 cycles -> imem_addr=0 stable over 3 req cycles; instr=16'h1234, opcode=1, isaluop=1, busy falls the cycle after ack.
- instr=16'hE000, jump_target=16'h040, do_next -> pc=16'h0040; next fetch has imem_addr=16'h0040.
- instr=16'hF0FE at pc=16'h0010: do_next with take_branch=1 -> pc=16'h000F; repeated from pc=16'h0010 with take_branch=0 -> pc=16'h0011.
- pc=16'hFFFF, instr=16'h2000, do_next -> pc=16'h0000; do_fetch and do_next together in IDLE -> pc unchanged, seq_error=1.
- rst_n pulsed low during WAIT, ack arriving 1 cycle after release -> imem_req=0 asynchronously, pc=RESET_PC, instr remains 0.
- FETCH_TIMEOUT_EN defined, no ack ever -> after 255 WAIT cycles imem_req=0, fetch_fault=1, busy=0; a subsequent fetch with ack works normally.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: one req/ack read per do_fetch, PC advance per do_next.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    WORD_SIZE      = 16,
  parameter int                    NIB_SIZE       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter logic [NIB_SIZE-1:0]   OP_JMP_CODE    = 'hE,
  parameter logic [NIB_SIZE-1:0]   OP_BR_CODE     = 'hF,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  do_fetch,
  input  logic                  do_next,
  input  logic                  take_branch,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0]  imem_rdata,
  input  logic                  imem_ack,
  output logic [WORD_SIZE-1:0]  instr,
  output logic [NIB_SIZE-1:0]   opcode,
  output logic                  isaluop,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  seq_error,
  output logic                  fetch_fault
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  instr_q, instr_d;
  logic                  seq_err_q, seq_err_d;
  logic [ADDR_WIDTH-1:0] br_off;

  assign br_off = {{(ADDR_WIDTH-8){instr_q[7]}}, instr_q[7:0]};

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    seq_err_d = seq_err_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
    fault_d   = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (do_fetch && do_next) begin
          seq_err_d = 1'b1;
        end else if (do_fetch) begin
          state_d = WAIT;
          addr_d  = pc_q;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (do_next) begin
          if (opcode == OP_JMP_CODE)
            pc_d = jump_target;
          else if (opcode == OP_BR_CODE && take_branch)
            pc_d = pc_q + ADDR_WIDTH'(1) + br_off;
          else
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
      end
      WAIT: begin
        // Strobes here are protocol violations; the fetch itself carries on.
        if (do_fetch || do_next) seq_err_d = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // Final allowed WAIT cycle passed without ack: abandon the read.
          instr_d = '0;
          state_d = IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      instr_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign fetch_fault = fault_q;
`else
  // Watchdog absent; the comparison only keeps TIMEOUT_CYCLES referenced.
  assign fetch_fault = (TIMEOUT_CYCLES < 0);
`endif

  assign imem_req  = (state_q == WAIT);
  assign busy      = (state_q == WAIT);
  assign imem_addr = addr_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[WORD_SIZE-1 -: NIB_SIZE];
  assign isaluop   = ~opcode[NIB_SIZE-1];
  assign pc        = pc_q;
  assign seq_error = seq_err_q;

endmodule
